// File: rtl/ntt_addr_gen_pkg.sv
// Shared constants, FSM state type and layer-length helper for the NTT address generator.
// The optional inter-layer gap is enabled by the NTT_LAYER_GAP_EN macro (see ntt_addr_gen).
package ntt_pkg;

    localparam int N                = 256;
    localparam int LOGN             = 8;
    localparam int KYBER_LAYERS     = 7;
    localparam int DILITHIUM_LAYERS = 8;

    localparam logic RED_KYBER = 1'b1;
    localparam logic BFLY_CT   = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } ntt_state_t;

    // Butterfly span of a layer in issue order: forward halves from 128,
    // inverse doubles up to 128 (Kyber skips the len=1 layer).
    function automatic logic [8:0] layer_len(input logic [2:0] layer,
                                             input logic       inverse,
                                             input logic       kyber);
        if (!inverse) begin
            return 9'd128 >> layer;
        end else if (kyber) begin
            return 9'd2 << layer;
        end else begin
            return 9'd1 << layer;
        end
    endfunction

endpackage

// File: rtl/ntt_addr_gen_if.sv
// Handshake/address bundle between the NTT address generator (master) and its butterfly consumer (slave).
interface ntt_addr_gen_if
    import ntt_pkg::*;
;
    logic            start;
    logic            selRed;
    logic            selButterfly;
    logic            ready;
    logic            valid;
    logic [LOGN-1:0] addrA;
    logic [LOGN-1:0] addrB;
    logic [LOGN-1:0] twiddleIdx;
    logic            selRedOut;
    logic            selButterflyOut;
    logic [2:0]      layer;
    logic            busy;
    logic            done;

    modport master (
        input  start, selRed, selButterfly, ready,
        output valid, addrA, addrB, twiddleIdx, selRedOut, selButterflyOut,
               layer, busy, done
    );

    modport slave (
        output start, selRed, selButterfly, ready,
        input  valid, addrA, addrB, twiddleIdx, selRedOut, selButterflyOut,
               layer, busy, done
    );

endinterface

// File: rtl/ntt_addr_gen.sv
// Address/twiddle schedule generator for 256-point Kyber/Dilithium NTT (CT forward, GS inverse).
// Define NTT_LAYER_GAP_EN to insert LAYER_GAP idle cycles between layers.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int LAYER_GAP = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       sel_red_i,
    input  logic       sel_butterfly_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] addr_a_o,
    output logic [7:0] addr_b_o,
    output logic [7:0] twiddle_idx_o,
    output logic       sel_red_o,
    output logic       sel_butterfly_o,
    output logic [2:0] layer_o,
    output logic       busy_o,
    output logic       done_o
);

    ntt_state_t state_q, state_d;
    logic [2:0] layer_q, layer_d;
    logic [8:0] grp_q, grp_d;
    logic [7:0] off_q, off_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] tw_q, tw_d;
    logic [7:0] addr_a_q, addr_a_d;
    logic [7:0] addr_b_q, addr_b_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       red_q, red_d;
    logic       bfly_q, bfly_d;

    logic [8:0] cur_len;
    logic [8:0] grp_step;
    logic [7:0] nxt_len;
    logic [7:0] tw_step;
    logic [2:0] last_layer;
    logic       fire;
    logic       last_in_group;
    logic       last_in_layer;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            layer_q  <= '0;
            grp_q    <= '0;
            off_q    <= '0;
            gap_q    <= '0;
            tw_q     <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            red_q    <= 1'b0;
            bfly_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            grp_q    <= grp_d;
            off_q    <= off_d;
            gap_q    <= gap_d;
            tw_q     <= tw_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            red_q    <= red_d;
            bfly_q   <= bfly_d;
        end
    end

    // Output registers always carry the beat being presented, so the next
    // beat is computed here and loaded on the edge that consumes the current one.
    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        grp_d    = grp_q;
        off_d    = off_q;
        gap_d    = gap_q;
        tw_d     = tw_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;
        red_d    = red_q;
        bfly_d   = bfly_q;

        cur_len       = layer_len(layer_q, bfly_q != BFLY_CT, red_q == RED_KYBER);
        nxt_len       = cur_len[7:0];
        grp_step      = grp_q + (cur_len << 1);
        tw_step       = (bfly_q == BFLY_CT) ? (tw_q + 8'd1) : (tw_q - 8'd1);
        last_layer    = (red_q == RED_KYBER) ? 3'(KYBER_LAYERS - 1) : 3'(DILITHIUM_LAYERS - 1);
        fire          = valid_q && ready_i;
        last_in_group = (({1'b0, off_q} + 9'd1) == cur_len);
        last_in_layer = last_in_group && (grp_step == 9'd256);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RUN;
                    red_d    = sel_red_i;
                    bfly_d   = sel_butterfly_i;
                    layer_d  = '0;
                    grp_d    = '0;
                    off_d    = '0;
                    nxt_len  = 8'(layer_len(3'd0, sel_butterfly_i != BFLY_CT,
                                            sel_red_i == RED_KYBER));
                    if (sel_butterfly_i == BFLY_CT) begin
                        tw_d = 8'd1;
                    end else begin
                        tw_d = (sel_red_i == RED_KYBER) ? 8'd127 : 8'd255;
                    end
                    addr_a_d = 8'd0;
                    addr_b_d = nxt_len;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end

            RUN: begin
                if (fire) begin
                    if (!last_in_group) begin
                        off_d    = off_q + 8'd1;
                        addr_a_d = addr_a_q + 8'd1;
                        addr_b_d = addr_b_q + 8'd1;
                    end else if (!last_in_layer) begin
                        off_d    = '0;
                        grp_d    = grp_step;
                        tw_d     = tw_step;
                        addr_a_d = grp_step[7:0];
                        addr_b_d = grp_step[7:0] + cur_len[7:0];
                    end else if (layer_q == last_layer) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        layer_d  = layer_q + 3'd1;
                        grp_d    = '0;
                        off_d    = '0;
                        tw_d     = tw_step;
                        nxt_len  = 8'(layer_len(layer_q + 3'd1, bfly_q != BFLY_CT,
                                                red_q == RED_KYBER));
                        addr_a_d = 8'd0;
                        addr_b_d = nxt_len;
`ifdef NTT_LAYER_GAP_EN
                        if (LAYER_GAP > 0) begin
                            state_d = GAP;
                            valid_d = 1'b0;
                            gap_d   = '0;
                        end
`endif
                    end
                end
            end

            // Next layer's first beat is already loaded; only valid is withheld.
            GAP: begin
                valid_d = 1'b0;
                if (gap_q == 8'(LAYER_GAP - 1)) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
                valid_d = 1'b0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign valid_o         = valid_q;
    assign addr_a_o        = addr_a_q;
    assign addr_b_o        = addr_b_q;
    assign twiddle_idx_o   = tw_q;
    assign sel_red_o       = red_q;
    assign sel_butterfly_o = bfly_q;
    assign layer_o         = layer_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule
